toggle_event_decoder: RTL and testbench

Receive side of a toggle-encoded event link. A T flip-flop based sender flips a single level line once per event, and this block recovers those events. It synchronises the line, detects each level change, and turns each change into a one-cycle event pulse. Events are queued in a pending counter and drained through a valid/ready interface, with a wrapping total counter and a sticky overflow flag. It sits at the destination end of any toggle-signalled event path, such as status or interrupt crossings.

---
 rtl/toggle_event_decoder.sv | 120 ++++++++++++
 tb/tb_toggle_event_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_decoder.sv
// Receive side of a toggle-encoded event link: synchronises the toggle line,
// turns each level change into an event, and queues events behind valid/ready.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int TOT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tog_in,
    output logic             ev_pulse,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [CNT_W-1:0] pend_cnt,
    output logic [TOT_W-1:0] total_cnt,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             armed
);

    typedef enum logic {
        ST_ARM,
        ST_RUN
    } state_e;

    localparam int ARM_W = 3;

    state_e                 state_q, state_d;
    logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q, prev_d;
    logic                   ev_pulse_q;
    logic [CNT_W-1:0]       pend_q, pend_d;
    logic [TOT_W-1:0]       total_q, total_d;
    logic                   ovf_q, ovf_d;

    logic sync_out;
    logic detect;
    logic accept;
    logic pend_full;

    assign sync_out  = sync_q[SYNC_STAGES-1];
    assign accept    = (pend_q != '0) && ev_ready;
    assign pend_full = (pend_q == '1);

    // Arming waits for the synchroniser to flush so the idle level of tog_in
    // is captured into prev rather than reported as an event.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        prev_d    = prev_q;
        detect    = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (arm_cnt_q == ARM_W'(SYNC_STAGES)) begin
                    prev_d  = sync_out;
                    state_d = ST_RUN;
                end else begin
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
                end
            end
            ST_RUN: begin
                if (sync_out != prev_q) begin
                    prev_d = sync_out;
                    detect = 1'b1;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    always_comb begin
        pend_d  = pend_q;
        ovf_d   = ovf_clr ? 1'b0 : ovf_q;
        total_d = total_q + TOT_W'(detect);
        if (detect && !accept) begin
            if (pend_full) begin
                ovf_d = 1'b1;  // a set in the same cycle as ovf_clr must win
            end else begin
                pend_d = pend_q + CNT_W'(1);
            end
        end else if (!detect && accept) begin
            pend_d = pend_q - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, exactly like real flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ARM;
            arm_cnt_q  <= '0;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            ev_pulse_q <= 1'b0;
            pend_q     <= '0;
            total_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], tog_in};
            prev_q     <= prev_d;
            ev_pulse_q <= detect;
            pend_q     <= pend_d;
            total_q    <= total_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ev_pulse  = ev_pulse_q;
    assign ev_valid  = (pend_q != '0);
    assign pend_cnt  = pend_q;
    assign total_cnt = total_q;
    assign ovf       = ovf_q;
    assign armed     = (state_q == ST_RUN);

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder: arming, latency, queueing,
// saturation/overflow and asynchronous reset, with hand-computed expectations.
module tb_toggle_event_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        tog_in;
    logic        ev_pulse;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  pend_cnt;
    logic [15:0] total_cnt;
    logic        ovf;
    logic        ovf_clr;
    logic        armed;

    int n_cmp = 0;
    int n_err = 0;

    toggle_event_decoder #(.SYNC_STAGES(2), .CNT_W(4), .TOT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .tog_in    (tog_in),
        .ev_pulse  (ev_pulse),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .pend_cnt  (pend_cnt),
        .total_cnt (total_cnt),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .armed     (armed)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one edge; outputs are sampled and inputs driven 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_and_wait3();
        tog_in = ~tog_in;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; tog_in = 1'b1; ev_ready = 1'b0; ovf_clr = 1'b0;
        #8;
        n_cmp++; if (armed !== 1'b0)     begin n_err++; $display("FAIL rst_armed: got %b want 0", armed); end
        n_cmp++; if (pend_cnt !== 4'd0)  begin n_err++; $display("FAIL rst_pend: got %0d want 0", pend_cnt); end
        n_cmp++; if (total_cnt !== 16'd0) begin n_err++; $display("FAIL rst_total: got %0d want 0", total_cnt); end
        n_cmp++; if (ovf !== 1'b0)       begin n_err++; $display("FAIL rst_ovf: got %b want 0", ovf); end
        n_cmp++; if (ev_pulse !== 1'b0)  begin n_err++; $display("FAIL rst_pulse: got %b want 0", ev_pulse); end
        #4 rst = 1'b0;  // released at 12 ns
        tick();
        n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL arm_edge1: got %b want 0", armed); end
        tick();
        n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL arm_edge2: got %b want 0", armed); end
        tick();
        n_cmp++; if (armed !== 1'b1) begin n_err++; $display("FAIL arm_edge3: got %b want 1", armed); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ev_pulse !== 1'b0 || total_cnt !== 16'd0 || pend_cnt !== 4'd0) begin
                n_err++; $display("FAIL arm_quiet[%0d]: pulse=%b total=%0d pend=%0d want 0/0/0", i, ev_pulse, total_cnt, pend_cnt);
            end
            tick();
        end
    endtask

    task automatic test_single_latency();
        tog_in = 1'b0;
        tick();
        n_cmp++; if (ev_pulse !== 1'b0) begin n_err++; $display("FAIL lat_e1_pulse: got %b want 0", ev_pulse); end
        tick();
        n_cmp++; if (ev_pulse !== 1'b0) begin n_err++; $display("FAIL lat_e2_pulse: got %b want 0", ev_pulse); end
        tick();
        n_cmp++; if (ev_pulse !== 1'b1) begin n_err++; $display("FAIL lat_e3_pulse: got %b want 1", ev_pulse); end
        n_cmp++; if (pend_cnt !== 4'd1) begin n_err++; $display("FAIL lat_pend: got %0d want 1", pend_cnt); end
        n_cmp++; if (ev_valid !== 1'b1) begin n_err++; $display("FAIL lat_valid: got %b want 1", ev_valid); end
        n_cmp++; if (total_cnt !== 16'd1) begin n_err++; $display("FAIL lat_total: got %0d want 1", total_cnt); end
        tick();
        n_cmp++; if (ev_pulse !== 1'b0) begin n_err++; $display("FAIL lat_e4_pulse: got %b want 0", ev_pulse); end
        n_cmp++; if (pend_cnt !== 4'd1) begin n_err++; $display("FAIL lat_e4_pend: got %0d want 1", pend_cnt); end
    endtask

    task automatic test_burst_drain();
        ev_ready = 1'b1; tick(); ev_ready = 1'b0;
        n_cmp++; if (pend_cnt !== 4'd0 || ev_valid !== 1'b0) begin
            n_err++; $display("FAIL pre_drain: pend=%0d valid=%b want 0/0", pend_cnt, ev_valid);
        end
        for (int i = 1; i <= 5; i++) begin
            toggle_and_wait3();
            n_cmp++; if (pend_cnt !== 4'(i)) begin n_err++; $display("FAIL burst_pend[%0d]: got %0d want %0d", i, pend_cnt, i); end
        end
        n_cmp++; if (total_cnt !== 16'd6) begin n_err++; $display("FAIL burst_total: got %0d want 6", total_cnt); end
        ev_ready = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            tick();
            n_cmp++; if (pend_cnt !== 4'(i)) begin n_err++; $display("FAIL drain_pend[%0d]: got %0d want %0d", i, pend_cnt, i); end
        end
        n_cmp++; if (ev_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", ev_valid); end
        tick();
        n_cmp++; if (pend_cnt !== 4'd0) begin n_err++; $display("FAIL no_underflow: got %0d want 0", pend_cnt); end
        ev_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        toggle_and_wait3();
        toggle_and_wait3();
        n_cmp++; if (pend_cnt !== 4'd2) begin n_err++; $display("FAIL sim_pre_pend: got %0d want 2", pend_cnt); end
        tog_in = ~tog_in;
        tick(); tick();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        n_cmp++; if (ev_pulse !== 1'b1) begin n_err++; $display("FAIL sim_pulse: got %b want 1", ev_pulse); end
        n_cmp++; if (pend_cnt !== 4'd2) begin n_err++; $display("FAIL sim_pend: got %0d want 2", pend_cnt); end
        n_cmp++; if (total_cnt !== 16'd9) begin n_err++; $display("FAIL sim_total: got %0d want 9", total_cnt); end
        ev_ready = 1'b1; tick(); tick(); ev_ready = 1'b0;
        n_cmp++; if (pend_cnt !== 4'd0) begin n_err++; $display("FAIL sim_drain: got %0d want 0", pend_cnt); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 15; i++) toggle_and_wait3();
        n_cmp++; if (pend_cnt !== 4'd15 || ovf !== 1'b0) begin
            n_err++; $display("FAIL sat15: pend=%0d ovf=%b want 15/0", pend_cnt, ovf);
        end
        toggle_and_wait3();
        n_cmp++; if (pend_cnt !== 4'd15) begin n_err++; $display("FAIL ovf_pend: got %0d want 15", pend_cnt); end
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", ovf); end
        n_cmp++; if (total_cnt !== 16'd25) begin n_err++; $display("FAIL ovf_total: got %0d want 25", total_cnt); end
        // 17th toggle with a coincident clear: the set must win
        tog_in = ~tog_in;
        tick(); tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins: got %b want 1", ovf); end
        n_cmp++; if (total_cnt !== 16'd26) begin n_err++; $display("FAIL ovf_total17: got %0d want 26", total_cnt); end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr: got %b want 0", ovf); end
        n_cmp++; if (pend_cnt !== 4'd15) begin n_err++; $display("FAIL ovf_clr_pend: got %0d want 15", pend_cnt); end
        // event at saturation with a coincident accept: no overflow
        tog_in = ~tog_in;
        tick(); tick();
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        n_cmp++; if (pend_cnt !== 4'd15 || ovf !== 1'b0) begin
            n_err++; $display("FAIL sat_accept: pend=%0d ovf=%b want 15/0", pend_cnt, ovf);
        end
        n_cmp++; if (total_cnt !== 16'd27) begin n_err++; $display("FAIL sat_accept_total: got %0d want 27", total_cnt); end
        toggle_and_wait3();
        n_cmp++; if (ovf !== 1'b1 || total_cnt !== 16'd28) begin
            n_err++; $display("FAIL ovf_again: ovf=%b total=%0d want 1/28", ovf, total_cnt);
        end
    endtask

    task automatic test_async_reset();
        ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        ev_ready = 1'b0;
        n_cmp++; if (pend_cnt !== 4'd7) begin n_err++; $display("FAIL ar_pre_pend: got %0d want 7", pend_cnt); end
        #3 rst = 1'b1; tog_in = 1'b0;
        #2;
        n_cmp++; if (pend_cnt !== 4'd0)   begin n_err++; $display("FAIL ar_pend: got %0d want 0", pend_cnt); end
        n_cmp++; if (total_cnt !== 16'd0) begin n_err++; $display("FAIL ar_total: got %0d want 0", total_cnt); end
        n_cmp++; if (ovf !== 1'b0)        begin n_err++; $display("FAIL ar_ovf: got %b want 0", ovf); end
        n_cmp++; if (armed !== 1'b0)      begin n_err++; $display("FAIL ar_armed: got %b want 0", armed); end
        n_cmp++; if (ev_valid !== 1'b0)   begin n_err++; $display("FAIL ar_valid: got %b want 0", ev_valid); end
        tick();
        tog_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL rearm_e1: got %b want 0", armed); end
        tick();
        n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL rearm_e2: got %b want 0", armed); end
        tick();
        n_cmp++; if (armed !== 1'b1) begin n_err++; $display("FAIL rearm_e3: got %b want 1", armed); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (ev_pulse !== 1'b0 || total_cnt !== 16'd0) begin
                n_err++; $display("FAIL rearm_quiet[%0d]: pulse=%b total=%0d want 0/0", i, ev_pulse, total_cnt);
            end
            tick();
        end
        toggle_and_wait3();
        n_cmp++; if (total_cnt !== 16'd1 || pend_cnt !== 4'd1) begin
            n_err++; $display("FAIL rearm_event: total=%0d pend=%0d want 1/1", total_cnt, pend_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_burst_drain();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
